// File: rtl/dl11_ctl.sv
// DL11 serial line controller: bus registers, baud generation
// and request/acknowledge sequencing toward an external UART.
module dl11_ctl #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic        rxclk,
    output logic        txclk,
    output logic        ld_tx_req,
    input  logic        ld_tx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    input  logic        tx_empty,
    output logic        uld_rx_req,
    input  logic        uld_rx_ack,
    input  logic [7:0]  rx_data,
    output logic        rx_enable,
    input  logic        rx_empty,
    output logic        rx_int,
    output logic        tx_int
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);
    // Empty flags come out of reset as "empty" so RX stays idle.
    localparam logic [3:0] SYNC_RST = 4'b0011;

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL, T_DRAIN} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} rx_state_t;

    tx_state_t   tx_state;
    rx_state_t   rx_state;
    logic [CW-1:0] div_cnt;
    logic [2:0]  tx_cnt;
    logic [3:0]  sync_a;
    logic [3:0]  sync_b;
    logic        ld_tx_ack_s;
    logic        uld_rx_ack_s;
    logic        tx_empty_s;
    logic        rx_empty_s;
    logic        rie;
    logic        rena;
    logic        tie;
    logic        tena;
    logic        ready;
    logic        done;
    logic [7:0]  rbuf;
    logic [15:0] rd_mux;
    logic        rd_rbuf;
    logic        wr_rcsr;
    logic        wr_xcsr;
    logic        wr_xbuf;
    logic        unused_wdata;

    assign ld_tx_ack_s  = sync_b[3];
    assign uld_rx_ack_s = sync_b[2];
    assign tx_empty_s   = sync_b[1];
    assign rx_empty_s   = sync_b[0];

    assign rd_rbuf = bus_rd && (bus_addr == 2'd1);
    assign wr_rcsr = bus_wr && (bus_addr == 2'd0);
    assign wr_xcsr = bus_wr && (bus_addr == 2'd2);
    assign wr_xbuf = bus_wr && (bus_addr == 2'd3) && ready;

    assign rx_enable = rena;
    assign tx_enable = tena;

    assign unused_wdata = ^{bus_wdata[15:8], bus_wdata[5:1]};

    // Baud generator: rxclk toggles at terminal count, txclk every 8th rxclk rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            rxclk   <= 1'b0;
            tx_cnt  <= 3'd0;
            txclk   <= 1'b0;
        end else if (div_cnt == DIV_TC) begin
            div_cnt <= '0;
            rxclk   <= ~rxclk;
            if (!rxclk) begin
                tx_cnt <= tx_cnt + 3'd1;
                if (tx_cnt == 3'd7) begin
                    txclk <= ~txclk;
                end
            end
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Two-flop synchronizers for the UART handshake and status inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= SYNC_RST;
            sync_b <= SYNC_RST;
        end else begin
            sync_a <= {ld_tx_ack, uld_rx_ack, tx_empty, rx_empty};
            sync_b <= sync_a;
        end
    end

    // Register read multiplexer.
    always_comb begin
        rd_mux = '0;
        unique case (bus_addr)
            2'd0:    rd_mux = {8'b0, done, rie, 5'b0, rena};
            2'd1:    rd_mux = {8'b0, rbuf};
            2'd2:    rd_mux = {8'b0, ready, tie, 5'b0, tena};
            default: rd_mux = '0;
        endcase
    end

    // Bus response: one-cycle ack, data only alongside the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ack   <= bus_rd | bus_wr;
            bus_rdata <= bus_rd ? rd_mux : 16'h0000;
        end
    end

    // Writable control bits of RCSR and XCSR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rie  <= 1'b0;
            rena <= 1'b1;
            tie  <= 1'b0;
            tena <= 1'b1;
        end else begin
            if (wr_rcsr) begin
                rie  <= bus_wdata[6];
                rena <= bus_wdata[0];
            end
            if (wr_xcsr) begin
                tie  <= bus_wdata[6];
                tena <= bus_wdata[0];
            end
        end
    end

    // TX FSM: load handshake, then wait for the UART to drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state  <= T_IDLE;
            ld_tx_req <= 1'b0;
            tx_data   <= 8'h00;
            ready     <= 1'b1;
        end else begin
            unique case (tx_state)
                T_IDLE: begin
                    if (wr_xbuf) begin
                        tx_data   <= bus_wdata[7:0];
                        ready     <= 1'b0;
                        ld_tx_req <= 1'b1;
                        tx_state  <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (ld_tx_ack_s) begin
                        ld_tx_req <= 1'b0;
                        tx_state  <= T_REL;
                    end
                end
                T_REL: begin
                    if (!ld_tx_ack_s) begin
                        tx_state <= T_DRAIN;
                    end
                end
                T_DRAIN: begin
                    if (tx_empty_s) begin
                        ready    <= 1'b1;
                        tx_state <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // RX FSM: unload one character when RBUF is free; capture beats read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= R_IDLE;
            uld_rx_req <= 1'b0;
            rbuf       <= 8'h00;
            done       <= 1'b0;
        end else begin
            if (rd_rbuf) begin
                done <= 1'b0;
            end
            unique case (rx_state)
                R_IDLE: begin
                    if (!rx_empty_s && !done) begin
                        uld_rx_req <= 1'b1;
                        rx_state   <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (uld_rx_ack_s) begin
                        uld_rx_req <= 1'b0;
                        rx_state   <= R_REL;
                    end
                end
                R_REL: begin
                    if (!uld_rx_ack_s) begin
                        rbuf     <= rx_data;
                        done     <= 1'b1;
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Registered level interrupts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_int <= 1'b0;
            tx_int <= 1'b0;
        end else begin
            rx_int <= rie & done;
            tx_int <= tie & ready;
        end
    end

endmodule
